addsub_seq: RTL and testbench
=============================

Name: addsub_seq

Overview:
- Parametrised, multi-cycle integer adder/subtractor for the execute stage; successor to the 32-bit combinational add/sub.
- Computes A+B or A−B (A + ~B + 1) one SLICE-bit chunk per clock, carrying between chunks in a register, so wide operands do not create a long combinational carry path.
- Valid/ready handshake on both input and output; produces sum plus carry, signed-overflow, zero and negative flags for branch/compare logic.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥2.
- SLICE, 8, bits added per cycle; must divide WIDTH exactly. N = WIDTH/SLICE cycles per operation.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  high only in IDLE and rst low; transfer when in_valid && in_ready at a rising edge
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1 = A−B, 0 = A+B
- out_valid  output  1  result valid; registered
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  result, registered
- co  output  1  carry out of MSB (for sub: 1 = no borrow)
- ov  output  1  signed overflow = carry into MSB XOR carry out of MSB
- zf  output  1  s == 0
- nf  output  1  s[WIDTH-1]

Behaviour:
- Reset: rst high at a rising edge → state IDLE, out_valid=0, s=0, co=ov=zf=nf=0, slice counter=0, carry register=0. in_ready=0 while rst high. Reset mid-CALC or in DONE aborts; the operation is discarded and never presented.
- States: IDLE → CALC → DONE → IDLE.
- IDLE: in_ready=1. On in_valid: latch a, b' = sub ? ~b : b, and carry-in = sub; counter=0; go to CALC. Inputs are ignored once latched; changes on a/b/sub after acceptance have no effect.
- CALC: each cycle, add slice k (bits k*SLICE+SLICE-1 .. k*SLICE) of a and b' plus the carry register, write to result slice k, and update the carry register. Counter increments. After slice N−1, capture co (final carry) and ov (carry into the MSB XOR co), and go to DONE.
- Latency: acceptance at edge T0; out_valid rises after edge T0+N. For SLICE==WIDTH, N=1.
- DONE: out_valid=1; s and flags are stable and do not change while out_valid=1. zf and nf are derived from the completed s. When out_ready=1 at an edge, out_valid→0 and the state returns to IDLE. in_ready stays 0 in DONE, so there is no overlapping accept. A new operation can be accepted at the earliest on the edge after the return to IDLE. Throughput is therefore one op per N+2 cycles.
- out_ready is ignored outside DONE.
- s and flags hold their last value in IDLE and CALC; only out_valid qualifies them.
- Arithmetic is modular 2^WIDTH; no saturation. Flags follow two's-complement conventions identical to the combinational unit.

Test Plan:
- WIDTH=32, SLICE=8: a=5, b=3, sub=0 → after 4 cycles out_valid=1, s=0x00000008, co=0, ov=0, zf=0, nf=0.
- Inter-slice carry: a=0x000000FF, b=1, sub=0 → s=0x00000100; a=0xFFFFFFFF, b=1 → s=0, co=1, zf=1, ov=0.
- Overflow and subtract: a=0x7FFFFFFF, b=1, add → s=0x80000000, ov=1, nf=1, co=0. a=3, b=5, sub=1 → s=0xFFFFFFFE, co=0, nf=1, ov=0. a=5, b=5, sub=1 → s=0, co=1, zf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_valid, s and flags stay constant and in_ready=0. Change a/b during CALC → result unaffected. Raise out_ready → IDLE next cycle, and a back-to-back op is accepted with correct result.
- Reset mid-op: assert rst during the 2nd CALC cycle → next cycle out_valid=0, s=0, flags=0, in_ready=1 after rst drops. A new op then completes correctly with no stale carry.
- Parameter sweep: WIDTH=16, SLICE=16 (N=1) and WIDTH=64, SLICE=4 (N=16) → random add/sub compared against a reference model for s, co and ov; latency equals N.

Source files
------------

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract: one SLICE-bit chunk per clock, with a registered carry between chunks.
// Result and flags are published together when the last slice completes.
module addsub_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             zf,
    output logic             nf
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             co_q, co_d, ov_q, ov_d, zf_q, zf_d, nf_q, nf_d;

    logic [SLICE-1:0] a_sl, b_sl;
    logic [SLICE:0]   sum;
    logic             last;

    always_comb begin
        a_sl = a_q[int'(cnt_q) * SLICE +: SLICE];
        b_sl = b_q[int'(cnt_q) * SLICE +: SLICE];
        sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
        last = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        co_d    = co_q;
        ov_d    = ov_q;
        zf_d    = zf_q;
        nf_d    = nf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // r_q is a private accumulator so s stays stable until the op completes
                r_d[int'(cnt_q) * SLICE +: SLICE] = sum[SLICE-1:0];
                carry_d = sum[SLICE];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    s_d     = r_d;
                    co_d    = sum[SLICE];
                    // carry into the MSB recovered from its sum bit: a ^ b' ^ s
                    ov_d    = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ r_d[WIDTH-1] ^ sum[SLICE];
                    zf_d    = (r_d == '0);
                    nf_d    = r_d[WIDTH-1];
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign s         = s_q;
    assign co        = co_q;
    assign ov        = ov_q;
    assign zf        = zf_q;
    assign nf        = nf_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: directed table at 32/8, reset abort, and random sweeps at 16/16 and 64/4.
module tb_addsub_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // 32/8 instance
    logic        iv32 = 0, ir32, sb32 = 0, ovl32, ordy32 = 0, co32, ov32, zf32, nf32;
    logic [31:0] a32 = 0, b32 = 0, s32;
    // 16/16 instance
    logic        iv16 = 0, ir16, sb16 = 0, ovl16, ordy16 = 0, co16, ov16, zf16, nf16;
    logic [15:0] a16 = 0, b16 = 0, s16;
    // 64/4 instance
    logic        iv64 = 0, ir64, sb64 = 0, ovl64, ordy64 = 0, co64, ov64, zf64, nf64;
    logic [63:0] a64 = 0, b64 = 0, s64;

    addsub_seq #(.WIDTH(32), .SLICE(8)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .sub(sb32),
        .out_valid(ovl32), .out_ready(ordy32), .s(s32), .co(co32), .ov(ov32), .zf(zf32), .nf(nf32)
    );
    addsub_seq #(.WIDTH(16), .SLICE(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sub(sb16),
        .out_valid(ovl16), .out_ready(ordy16), .s(s16), .co(co16), .ov(ov16), .zf(zf16), .nf(nf16)
    );
    addsub_seq #(.WIDTH(64), .SLICE(4)) u64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64), .sub(sb64),
        .out_valid(ovl64), .out_ready(ordy64), .s(s64), .co(co64), .ov(ov64), .zf(zf64), .nf(nf64)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        co, ov, zf, nf;
        int          hold;
    } vec_t;

    typedef struct {
        logic [63:0] s;
        logic        co, ov, zf, nf;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) $display("FAIL %s: actual=%h required=%h", nm, act, req);
        else passed++;
    endtask

    // Independent reference: full-width add, overflow from operand/result signs.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                   input int w);
        exp_t        e;
        logic [63:0] mask, bb;
        logic [64:0] t;
        logic        am, bm, sm;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        bb   = (sub ? ~b : b) & mask;
        t    = {1'b0, a & mask} + {1'b0, bb} + {64'd0, sub};
        e.s  = t[63:0] & mask;
        e.co = t[w];
        am   = a[w-1];
        bm   = b[w-1];
        sm   = e.s[w-1];
        e.ov = sub ? ((am != bm) && (sm != am)) : ((am == bm) && (sm != am));
        e.zf = (e.s == 64'd0);
        e.nf = sm;
        return e;
    endfunction

    task automatic op32(input vec_t v);
        int   n;
        exp_t e;
        n = 0;
        while (!ir32 && n < 20) begin @(negedge clk); n++; end
        chk("in_ready32", {63'd0, ir32}, 64'd1);
        a32 = v.a; b32 = v.b; sb32 = v.sub; iv32 = 1;
        @(posedge clk);
        sbq.push_back('{s: {32'd0, v.s}, co: v.co, ov: v.ov, zf: v.zf, nf: v.nf});
        @(negedge clk);
        // operands scrambled after acceptance must not affect the result
        iv32 = 0; a32 = ~v.a; b32 = v.b ^ 32'h5a5a_5a5a; sb32 = ~v.sub;
        n = 0;
        while (!ovl32 && n < 64) begin @(negedge clk); n++; end
        chk("latency32", 64'(n), 64'd4);
        for (int i = 0; i < v.hold; i++) begin
            chk("hold_valid32", {63'd0, ovl32}, 64'd1);
            chk("hold_s32", {32'd0, s32}, sbq[0].s);
            chk("hold_co32", {63'd0, co32}, {63'd0, sbq[0].co});
            chk("hold_in_ready32", {63'd0, ir32}, 64'd0);
            @(negedge clk);
        end
        e = sbq.pop_front();
        chk("s32", {32'd0, s32}, e.s);
        chk("co32", {63'd0, co32}, {63'd0, e.co});
        chk("ov32", {63'd0, ov32}, {63'd0, e.ov});
        chk("zf32", {63'd0, zf32}, {63'd0, e.zf});
        chk("nf32", {63'd0, nf32}, {63'd0, e.nf});
        ordy32 = 1;
        @(posedge clk);
        @(negedge clk);
        ordy32 = 0;
        chk("out_valid_drop32", {63'd0, ovl32}, 64'd0);
        chk("in_ready_back32", {63'd0, ir32}, 64'd1);
    endtask

    task automatic op16(input logic [15:0] a_v, input logic [15:0] b_v, input logic sub_v);
        int   n;
        exp_t e;
        n = 0;
        while (!ir16 && n < 20) begin @(negedge clk); n++; end
        a16 = a_v; b16 = b_v; sb16 = sub_v; iv16 = 1;
        @(posedge clk);
        sbq.push_back(model({48'd0, a_v}, {48'd0, b_v}, sub_v, 16));
        @(negedge clk);
        iv16 = 0; a16 = ~a_v;
        n = 0;
        while (!ovl16 && n < 64) begin @(negedge clk); n++; end
        chk("latency16", 64'(n), 64'd1);
        e = sbq.pop_front();
        chk("s16", {48'd0, s16}, e.s);
        chk("co16", {63'd0, co16}, {63'd0, e.co});
        chk("ov16", {63'd0, ov16}, {63'd0, e.ov});
        ordy16 = 1;
        @(posedge clk);
        @(negedge clk);
        ordy16 = 0;
    endtask

    task automatic op64(input logic [63:0] a_v, input logic [63:0] b_v, input logic sub_v);
        int   n;
        exp_t e;
        n = 0;
        while (!ir64 && n < 20) begin @(negedge clk); n++; end
        a64 = a_v; b64 = b_v; sb64 = sub_v; iv64 = 1;
        @(posedge clk);
        sbq.push_back(model(a_v, b_v, sub_v, 64));
        @(negedge clk);
        iv64 = 0; b64 = ~b_v;
        n = 0;
        while (!ovl64 && n < 64) begin @(negedge clk); n++; end
        chk("latency64", 64'(n), 64'd16);
        e = sbq.pop_front();
        chk("s64", s64, e.s);
        chk("co64", {63'd0, co64}, {63'd0, e.co});
        chk("ov64", {63'd0, ov64}, {63'd0, e.ov});
        ordy64 = 1;
        @(posedge clk);
        @(negedge clk);
        ordy64 = 0;
    endtask

    initial begin
        //           a             b             sub   s             co ov zf nf hold
        tbl[0] = '{32'd5,        32'd3,        1'b0, 32'h0000_0008, 0, 0, 0, 0, 0};
        tbl[1] = '{32'h0000_00FF, 32'd1,       1'b0, 32'h0000_0100, 0, 0, 0, 0, 0};
        tbl[2] = '{32'hFFFF_FFFF, 32'd1,       1'b0, 32'h0000_0000, 1, 0, 1, 0, 3};
        tbl[3] = '{32'h7FFF_FFFF, 32'd1,       1'b0, 32'h8000_0000, 0, 1, 0, 1, 0};
        tbl[4] = '{32'd3,        32'd5,        1'b1, 32'hFFFF_FFFE, 0, 0, 0, 1, 2};
        tbl[5] = '{32'd5,        32'd5,        1'b1, 32'h0000_0000, 1, 0, 1, 0, 0};
        tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1, 1, 1, 0, 0};
        tbl[7] = '{32'h8000_0000, 32'd1,       1'b1, 32'h7FFF_FFFF, 1, 1, 0, 0, 0};
        tbl[8] = '{32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 0, 0, 0, 0, 0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, ir32}, 64'd0);
        chk("rst_out_valid", {63'd0, ovl32}, 64'd0);
        chk("rst_s", {32'd0, s32}, 64'd0);
        chk("rst_flags", {60'd0, co32, ov32, zf32, nf32}, 64'd0);
        rst = 0;
        #1;
        chk("idle_in_ready", {63'd0, ir32}, 64'd1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) op32(tbl[i]);

        // Abort an op mid-calculation; carry is live at that point.
        a32 = 32'hFFFF_FFFF; b32 = 32'd1; sb32 = 0; iv32 = 1;
        @(posedge clk);
        @(negedge clk);
        iv32 = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_out_valid", {63'd0, ovl32}, 64'd0);
        chk("abort_s", {32'd0, s32}, 64'd0);
        chk("abort_flags", {60'd0, co32, ov32, zf32, nf32}, 64'd0);
        chk("abort_in_ready_rst", {63'd0, ir32}, 64'd0);
        rst = 0;
        #1;
        chk("abort_in_ready", {63'd0, ir32}, 64'd1);
        @(negedge clk);
        op32(tbl[8]);

        op16(16'h7FFF, 16'h0001, 1'b0);
        op16(16'h8000, 16'h0001, 1'b1);
        op16(16'hFFFF, 16'hFFFF, 1'b0);
        for (int i = 0; i < 12; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom));

        op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        op64(64'd0, 64'd1, 1'b1);
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        for (int i = 0; i < 12; i++)
            op64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
